// File: rtl/t09_display_pkg.sv
// Shared types and 7-segment glyph constants for the score display.
package t09_display_pkg;

  typedef enum logic [1:0] {
    ONES     = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/t09_bcd_to_7seg.sv
// Combinational BCD digit to 7-segment glyph, with blanking and a dash for illegal codes.
module t09_bcd_to_7seg
  import t09_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      if (i_bcd > 4'd9) begin
        o_seg = SEG_DASH;
      end else begin
        o_seg = SEG_DIGIT[i_bcd];
      end
    end
  end

endmodule

// File: rtl/t09_score_display.sv
// 3-digit multiplexed score display: per-frame input snapshot, leading-zero
// blanking, and whole-display blink while the game-complete flag is latched.
module t09_score_display
  import t09_display_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int BLINK_FRAMES  = 64,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_hundreds,
  input  logic       isGameComplete,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       AN_OFF     = {3{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0] r_scan_cnt;
  digit_idx_t       r_digit_idx;
  logic             r_first;
  logic [3:0]       r_sh_ones;
  logic [3:0]       r_sh_tens;
  logic [3:0]       r_sh_hundreds;
  logic             r_sh_complete;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_on;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_frame_tick;

  logic             w_scan_last;
  logic             w_boundary;
  logic [3:0]       w_sel_bcd;
  logic             w_sel_blank;
  logic [2:0]       w_an_onehot;
  logic [6:0]       w_seg;

  assign w_scan_last = (r_scan_cnt == SCAN_LAST);
  // The first cycle out of reset acts as an extra snapshot point.
  assign w_boundary  = r_first || (w_scan_last && (r_digit_idx == HUNDREDS));

  always_comb begin
    w_sel_bcd   = r_sh_ones;
    w_sel_blank = 1'b0;
    w_an_onehot = 3'b001;
    case (r_digit_idx)
      TENS: begin
        w_sel_bcd   = r_sh_tens;
        w_sel_blank = (r_sh_hundreds == 4'd0) && (r_sh_tens == 4'd0);
        w_an_onehot = 3'b010;
      end
      HUNDREDS: begin
        w_sel_bcd   = r_sh_hundreds;
        w_sel_blank = (r_sh_hundreds == 4'd0);
        w_an_onehot = 3'b100;
      end
      default: begin
        w_sel_bcd   = r_sh_ones;
        w_sel_blank = 1'b0;
        w_an_onehot = 3'b001;
      end
    endcase
  end

  t09_bcd_to_7seg u_dec (
    .i_bcd   (w_sel_bcd),
    .i_blank (w_sel_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt    <= '0;
      r_digit_idx   <= ONES;
      r_first       <= 1'b1;
      r_sh_ones     <= 4'd0;
      r_sh_tens     <= 4'd0;
      r_sh_hundreds <= 4'd0;
      r_sh_complete <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_on    <= 1'b1;
      r_seg         <= SEG_BLANK;
      r_an          <= AN_OFF;
      r_frame_tick  <= 1'b0;
    end else begin
      r_first      <= 1'b0;
      r_frame_tick <= w_boundary;

      if (!r_first) begin
        if (w_scan_last) begin
          r_scan_cnt <= '0;
          case (r_digit_idx)
            ONES:    r_digit_idx <= TENS;
            TENS:    r_digit_idx <= HUNDREDS;
            default: r_digit_idx <= ONES;
          endcase
        end else begin
          r_scan_cnt <= r_scan_cnt + 1'b1;
        end
      end

      if (w_boundary) begin
        r_sh_ones     <= bcd_ones;
        r_sh_tens     <= bcd_tens;
        r_sh_hundreds <= bcd_hundreds;
        r_sh_complete <= isGameComplete;
        if (isGameComplete) begin
          if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end else begin
          r_blink_cnt <= '0;
          r_blink_on  <= 1'b1;
        end
      end

      // Outputs reflect the digit selected during the previous cycle.
      if (r_first || (r_sh_complete && !r_blink_on)) begin
        r_seg <= SEG_BLANK;
        r_an  <= AN_OFF;
      end else begin
        r_seg <= w_seg;
        r_an  <= w_an_onehot ^ AN_OFF;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_t09_score_display.sv
// Randomized self-checking bench for t09_score_display with a frame-level reference model.
module tb_t09_score_display;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 3 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_hundreds;
  logic       gc;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_tick;

  always #5 clk = ~clk;

  t09_score_display #(
    .SCAN_DIV      (SD),
    .BLINK_FRAMES  (BF),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bcd_ones       (bcd_ones),
    .bcd_tens       (bcd_tens),
    .bcd_hundreds   (bcd_hundreds),
    .isGameComplete (gc),
    .seg            (seg),
    .an             (an),
    .frame_tick     (frame_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Model: the digits shown in the current frame, and how many consecutive
  // snapshots have seen the game-complete flag high.
  int m_o, m_t, m_h;
  bit m_gc;
  int m_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=0x%0h exp=0x%0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic bit model_off();
    return m_gc && (((m_run / BF) % 2) == 1);
  endfunction

  task automatic step(input bit r);
    logic [6:0] e_seg;
    logic [2:0] e_an;
    logic       e_tick;
    int         slot;
    int         d;
    bit         blank;
    rst = r;
    @(posedge clk);
    e_seg  = 7'h00;
    e_an   = 3'b111;
    e_tick = 1'b0;
    if (r) begin
      edge_n = 0;
      m_o = 0; m_t = 0; m_h = 0; m_gc = 1'b0; m_run = 0;
    end else begin
      edge_n++;
      e_tick = (((edge_n - 1) % FR) == 0);
      if (edge_n > 1) begin
        slot = ((edge_n - 2) % FR) / SD;
        case (slot)
          0:       begin d = m_o; blank = 1'b0; end
          1:       begin d = m_t; blank = (m_h == 0) && (m_t == 0); end
          default: begin d = m_h; blank = (m_h == 0); end
        endcase
        if (!model_off()) begin
          e_seg = blank ? 7'h00 : glyph(d);
          e_an  = ~(3'(3'b001 << slot));
        end
      end
      if (e_tick) begin
        m_o = int'(bcd_ones);
        m_t = int'(bcd_tens);
        m_h = int'(bcd_hundreds);
        m_run = gc ? m_run + 1 : 0;
        m_gc = gc;
        $display("[TB] snapshot edge=%0d h/t/o=%0d/%0d/%0d complete=%0b blink_off=%0b",
                 edge_n, m_h, m_t, m_o, m_gc, model_off());
      end
    end
    #1;
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("frame_tick", 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic set_bcd(input int h, input int t, input int o);
    bcd_hundreds = 4'(h);
    bcd_tens     = 4'(t);
    bcd_ones     = 4'(o);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    gc  = 1'b0;
    set_bcd(0, 0, 0);
    repeat (3) step(1'b1);

    // Score 140, then zero-blanking cases.
    set_bcd(1, 4, 0);
    repeat (2 * FR + 2) step(1'b0);
    set_bcd(0, 0, 7);
    repeat (FR + 2) step(1'b0);
    set_bcd(0, 0, 0);
    repeat (FR + 2) step(1'b0);

    // Change input one cycle after a frame boundary: no tearing.
    set_bcd(0, 1, 2);
    repeat (FR) step(1'b0);
    guard = 0;
    while ((((edge_n - 1) % FR) != 1) && guard < FR) begin
      step(1'b0);
      guard++;
    end
    set_bcd(0, 3, 5);
    repeat (2 * FR + 1) step(1'b0);

    // Game complete blink, then release.
    gc = 1'b1;
    set_bcd(0, 9, 9);
    repeat (6 * FR) step(1'b0);
    gc = 1'b0;
    repeat (2 * FR) step(1'b0);

    // Illegal BCD shows a dash.
    set_bcd(0, 2, 12);
    repeat (FR + 2) step(1'b0);

    // Reset mid-frame while blinked off.
    gc = 1'b1;
    set_bcd(3, 0, 8);
    guard = 0;
    while (!model_off() && guard < 8 * FR) begin
      step(1'b0);
      guard++;
    end
    check_eq("blink_off_reached", 32'(model_off()), 32'd1);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (3 * FR) step(1'b0);
    gc = 1'b0;

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) begin
        set_bcd(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0,
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : 0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9)));
      end
      if ($urandom_range(0, 59) == 0) gc = ~gc;
      step($urandom_range(0, 399) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
